// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the MINI-RISC fetch stage: default widths, reset PC and opcode encodings.
package fetch_prefetch_unit_pkg;

  localparam int unsigned FPU_ADDR_W   = 11;
  localparam int unsigned FPU_INSTR_W  = 16;
  localparam int unsigned FPU_DEPTH    = 4;
  localparam int unsigned FPU_RESET_PC = 0;

  // Major opcode lives in the top nibble of every MINI-RISC instruction.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_JMP  = 4'hC,
    OP_JAL  = 4'hD,
    OP_JR   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; head is read combinationally.
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 27,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness masks anything stale at the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads under a credit limit and buffers results.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter  int unsigned           ADDR_W   = FPU_ADDR_W,
  parameter  int unsigned           INSTR_W  = FPU_INSTR_W,
  parameter  int unsigned           DEPTH    = FPU_DEPTH,
  parameter  logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(FPU_RESET_PC),
  localparam int unsigned           CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CW-1:0]      count,
  output logic               full
);

  localparam int unsigned QW    = INSTR_W + ADDR_W;
  localparam int unsigned OCC_W = CW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [OCC_W-1:0]  occ;
  logic              q_push, q_pop, q_flush, q_empty;
  logic [QW-1:0]     q_rdata;

  // Issue stage: a request is only made if its response is guaranteed a slot.
  always_comb begin
    occ      = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    imem_req = !rst && !redirect_valid && !halt && (occ < OCC_W'(DEPTH));
    q_push   = inflight_q && !redirect_valid && !rst;
    q_pop    = out_valid && out_ready && !redirect_valid && !rst;
    q_flush  = redirect_valid;

    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (imem_req) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  // Response stage: returned word is paired with the PC that requested it.
  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .wdata ({imem_rdata, inflight_pc_q}),
    .rdata (q_rdata),
    .count (count),
    .full  (full),
    .empty (q_empty)
  );

  assign imem_addr = pc_q;
  assign out_valid = !q_empty;
  assign out_instr = q_rdata[QW-1:ADDR_W];
  assign out_pc    = q_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: cycle table for startup/backpressure, scoreboard for the PC stream.
module tb_fetch_prefetch_unit;

  localparam int AW = 11;
  localparam int IW = 16;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] count;
  logic          full;

  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [IW-1:0] w_rdata;
  logic          w_valid;
  logic [IW-1:0] w_instr;
  logic [AW-1:0] w_pc;
  logic [CW-1:0] w_count;
  logic          w_full;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] expq [$];

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .RESET_PC(11'h000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count), .full(full)
  );

  fetch_prefetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .RESET_PC(11'h7FE)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_addr(11'h000), .halt(1'b0),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr), .out_pc(w_pc),
    .count(w_count), .full(w_full)
  );

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 16'h5A3C;
  endfunction

  // Instruction memory models, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= instr_of(imem_addr);
    if (w_req)    w_rdata    <= instr_of(w_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted head entry must be the next expected PC.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc=%0h want=none at %0t", out_pc, $time);
      end else begin
        logic [AW-1:0] e;
        e = expq.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, instr_of(e));
      end
    end
  end

  logic [AW-1:0] wexp [4];
  int widx  = 0;
  int wseen = 0;
  initial begin
    wexp[0] = 11'h7FE; wexp[1] = 11'h7FF; wexp[2] = 11'h000; wexp[3] = 11'h001;
  end

  always @(negedge clk) begin
    if (rst) widx = 0;
    else if (w_valid && widx < 4) begin
      chk("wrap_pc", w_pc, wexp[widx]);
      chk("wrap_instr", w_instr, instr_of(w_pc));
      widx++;
      if (widx == 4) wseen++;
    end
  end

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          req;
    logic [AW-1:0] addr;
    logic          vld;
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
    logic          full;
  } vec_t;

  function automatic vec_t mk(bit r, bit rd, bit rq, int ad, bit v, int p, int c, bit f);
    vec_t x;
    x.rst = r; x.rdy = rd; x.req = rq; x.addr = AW'(ad);
    x.vld = v; x.pc = AW'(p); x.cnt = CW'(c); x.full = f;
    return x;
  endfunction

  vec_t tbl [16];

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", expq.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst rdy req addr vld pc cnt full
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 2, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 3, 1, 0, 2, 0);
    tbl[5]  = mk(0, 0, 0, 4, 1, 0, 3, 0);
    for (int i = 6; i <= 10; i++) tbl[i] = mk(0, 0, 0, 4, 1, 0, 4, 1);
    tbl[11] = mk(0, 1, 0, 4, 1, 0, 4, 1);
    tbl[12] = mk(0, 1, 1, 4, 1, 1, 3, 0);
    tbl[13] = mk(0, 1, 1, 5, 1, 2, 2, 0);
    tbl[14] = mk(0, 1, 1, 6, 1, 3, 2, 0);
    tbl[15] = mk(0, 1, 1, 7, 1, 4, 2, 0);

    rst = 1'b1; out_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) expq.push_back(AW'(i));
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_req", imem_req, tbl[i].req);
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", out_valid, tbl[i].vld);
      chk("tbl_pc", out_pc, tbl[i].pc);
      chk("tbl_instr", out_instr, tbl[i].vld ? instr_of(tbl[i].pc) : 16'h0);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_full", full, tbl[i].full);
      @(posedge clk); #1;
    end

    // Redirect while head shows pc 5 and a fetch is in flight.
    redirect_valid = 1'b1;
    redirect_addr  = 11'h040;
    for (int i = 0; i < 16; i++) expq.push_back(AW'(11'h040 + i));
    @(negedge clk);
    chk("redir_head_pc", out_pc, 5);
    chk("redir_req", imem_req, 0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_n1_count", count, 0);
    chk("redir_n1_valid", out_valid, 0);
    chk("redir_n1_req", imem_req, 1);
    chk("redir_n1_addr", imem_addr, 11'h040);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir_n2_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir_n3_valid", out_valid, 1);
    chk("redir_n3_pc", out_pc, 11'h040);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir_n4_pc", out_pc, 11'h041);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Halt: no requests, queue drains, then resumes without skipping.
    halt = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      if (h == 4) begin
        chk("halt_count", count, 0);
        chk("halt_valid", out_valid, 0);
      end
      @(posedge clk); #1;
    end
    halt = 1'b0;
    @(negedge clk);
    chk("halt_resume_req", imem_req, 1);
    @(posedge clk); #1;
    drain();

    // Reset with three queued entries and one fetch in flight.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("prerst_count", count, 3);
    chk("prerst_req", imem_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_full", full, 0);
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) expq.push_back(AW'(i));
    out_ready = 1'b1;
    drain();

    chk("wrap_runs", (wseen >= 1), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
